// File: rtl/x_input_loader.sv
// X-matrix input loader: packs a byte stream into 32-bit words and writes them
// into a two-bank ping-pong SRAM, tracking which banks hold an unconsumed matrix.
module x_input_loader #(
    parameter int BYTES_PER_MATRIX = 32,
    parameter int DATA_W           = 8,
    parameter int WORD_W           = 32,
    parameter int WORDS_PER_BANK   = BYTES_PER_MATRIX / 4,
    parameter int ADDR_W           = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_in,
    input  logic              valid_input,
    input  logic [DATA_W-1:0] X_load,
    input  logic              release_in,
    input  logic              release_bank,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [WORD_W-1:0] mem_wdata,
    output logic              busy,
    output logic              load_done,
    output logic              done_bank,
    output logic [1:0]        bank_full,
    output logic              start_err,
    output logic              stray_err
);

    localparam int CNT_W  = $clog2(BYTES_PER_MATRIX);
    localparam int LANE_W = $clog2(WORD_W / DATA_W);
    localparam int IDX_W  = $clog2(WORDS_PER_BANK);

    typedef enum logic {IDLE, LOAD} state_t;

    state_t            state, state_next;
    logic              wr_bank;
    logic [CNT_W-1:0]  byte_cnt;
    logic [WORD_W-1:0] pack;
    logic [WORD_W-1:0] word_next;
    logic [LANE_W-1:0] lane;
    logic [IDX_W-1:0]  word_idx;
    logic              accept, last_byte, word_end;
    logic              start_ok, start_rej;
    logic [1:0]        bank_full_next;

    assign accept    = (state == LOAD) && valid_input;
    assign lane      = byte_cnt[LANE_W-1:0];
    assign word_idx  = byte_cnt[CNT_W-1 -: IDX_W];
    assign word_end  = &lane;
    assign last_byte = (byte_cnt == CNT_W'(BYTES_PER_MATRIX - 1));
    assign busy      = (state == LOAD);
    assign done_bank = wr_bank;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        start_ok   = 1'b0;
        start_rej  = 1'b0;
        case (state)
            IDLE: begin
                if (start_in) begin
                    if (bank_full[wr_bank]) begin
                        start_rej = 1'b1;
                    end else begin
                        start_ok   = 1'b1;
                        state_next = LOAD;
                    end
                end
            end
            LOAD: begin
                if (accept && last_byte) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Little-endian lane merge: the incoming byte completes the word in flight.
    always_comb begin
        word_next = pack;
        word_next[lane*DATA_W +: DATA_W] = X_load;
    end

    // A completion set overrides a same-cycle release of the same bank.
    always_comb begin
        bank_full_next = bank_full;
        if (release_in) bank_full_next[release_bank] = 1'b0;
        if (load_done)  bank_full_next[wr_bank]      = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            load_done <= 1'b0;
            bank_full <= 2'b00;
            start_err <= 1'b0;
            stray_err <= 1'b0;
            wr_bank   <= 1'b0;
            byte_cnt  <= '0;
            pack      <= '0;
        end else begin
            mem_we    <= accept && word_end;
            load_done <= accept && last_byte;
            start_err <= start_rej;
            bank_full <= bank_full_next;
            if (valid_input && (state == IDLE)) stray_err <= 1'b1;
            if (load_done) wr_bank <= ~wr_bank;
            if (start_ok) begin
                byte_cnt <= '0;
            end else if (accept) begin
                byte_cnt <= byte_cnt + 1'b1;
            end
            if (accept) begin
                pack <= word_next;
                if (word_end) begin
                    mem_wdata <= word_next;
                    mem_addr  <= {wr_bank, word_idx};
                end
            end
        end
    end

endmodule

// File: tb/tb_x_input_loader.sv
// Directed bench for x_input_loader with a write/completion scoreboard.
module tb_x_input_loader;

    logic        clk = 1'b0;
    logic        rst, start_in, valid_input, release_in, release_bank;
    logic [7:0]  X_load;
    logic        mem_we, busy, load_done, done_bank, start_err, stray_err;
    logic [3:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [1:0]  bank_full;

    int checks_total = 0;
    int checks_pass  = 0;
    int cyc          = 0;

    typedef struct {
        logic [3:0]  addr;
        logic [31:0] data;
        int          cyc;
    } wr_t;

    wr_t  wr_q[$];
    logic done_q[$];

    x_input_loader dut (
        .clk(clk), .rst(rst), .start_in(start_in), .valid_input(valid_input),
        .X_load(X_load), .release_in(release_in), .release_bank(release_bank),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .busy(busy),
        .load_done(load_done), .done_bank(done_bank), .bank_full(bank_full),
        .start_err(start_err), .stray_err(stray_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks_total++;
        assert (obs === exp) checks_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    always @(negedge clk) begin : monitor
        wr_t  e;
        logic b;
        if (!rst) begin
            if (mem_we) begin
                if (wr_q.size() == 0) begin
                    check("unexpected_we", 1, 0);
                end else begin
                    e = wr_q.pop_front();
                    check("wr_addr", mem_addr, e.addr);
                    check("wr_data", mem_wdata, e.data);
                    check("wr_cycle", cyc, e.cyc);
                end
            end
            if (load_done) begin
                if (done_q.size() == 0) begin
                    check("unexpected_done", 1, 0);
                end else begin
                    b = done_q.pop_front();
                    check("done_bank", done_bank, b);
                    check("done_with_we", mem_we, 1);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_req(input logic expect_err);
        start_in = 1'b1;
        tick();
        start_in = 1'b0;
        check("start_err", start_err, expect_err);
        check("busy_after_start", busy, !expect_err);
        if (expect_err) begin
            tick();
            check("start_err_pulse", start_err, 0);
            check("busy_after_reject", busy, 0);
        end
    endtask

    task automatic send_bytes(input logic [7:0] base, input int n, input logic gap,
                              input logic bank, input logic rel_at_done);
        logic [31:0] w;
        w = '0;
        for (int i = 0; i < n; i++) begin
            valid_input = 1'b1;
            X_load = base + 8'(i);
            w[8*(i%4) +: 8] = X_load;
            if (i % 4 == 3) wr_q.push_back('{addr: {bank, 3'(i/4)}, data: w, cyc: cyc + 1});
            if (i == 31) done_q.push_back(bank);
            tick();
            if (gap && i < n - 1) begin
                valid_input = 1'b0;
                tick();
            end
        end
        valid_input = 1'b0;
        if (n == 32) begin
            check("busy_drop", busy, 0);
            check("load_done", load_done, 1);
            if (rel_at_done) begin
                release_in   = 1'b1;
                release_bank = 1'b0;
            end
            tick();
            release_in = 1'b0;
            check("load_done_pulse", load_done, 0);
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_we"}, mem_we, 0);
        check({tag, "_addr"}, mem_addr, 0);
        check({tag, "_wdata"}, mem_wdata, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_load_done"}, load_done, 0);
        check({tag, "_done_bank"}, done_bank, 0);
        check({tag, "_bank_full"}, bank_full, 2'b00);
        check({tag, "_start_err"}, start_err, 0);
        check({tag, "_stray_err"}, stray_err, 0);
    endtask

    initial begin
        rst = 1'b1; start_in = 1'b0; valid_input = 1'b0; X_load = 8'h00;
        release_in = 1'b0; release_bank = 1'b0;
        tick();
        tick();
        check_zero("reset");
        rst = 1'b0;
        tick();

        // single matrix into bank 0
        start_req(1'b0);
        send_bytes(8'h00, 32, 1'b0, 1'b0, 1'b0);
        check("bank_full_single", bank_full, 2'b01);

        // ping-pong into bank 1
        start_req(1'b0);
        send_bytes(8'h80, 32, 1'b0, 1'b1, 1'b0);
        check("bank_full_pingpong", bank_full, 2'b11);

        // both banks full: reject, then release bank 0 and retry with gapped input
        start_req(1'b1);
        check("bank_full_reject", bank_full, 2'b11);
        release_in = 1'b1; release_bank = 1'b0;
        tick();
        release_in = 1'b0;
        check("bank_full_release0", bank_full, 2'b10);
        start_req(1'b0);
        send_bytes(8'h00, 32, 1'b1, 1'b0, 1'b0);
        check("bank_full_gapped", bank_full, 2'b11);

        // release bank 1, reload it, and release bank 0 in the load_done cycle
        release_in = 1'b1; release_bank = 1'b1;
        tick();
        release_in = 1'b0;
        check("bank_full_release1", bank_full, 2'b01);
        start_req(1'b0);
        send_bytes(8'h40, 32, 1'b0, 1'b1, 1'b1);
        check("bank_full_simultaneous", bank_full, 2'b10);

        // stray byte while idle
        check("stray_before", stray_err, 0);
        valid_input = 1'b1; X_load = 8'hEE;
        tick();
        valid_input = 1'b0;
        check("stray_set", stray_err, 1);
        tick();
        check("stray_sticky", stray_err, 1);
        check("stray_busy", busy, 0);

        // mid-load reset after 13 bytes into bank 0
        start_req(1'b0);
        send_bytes(8'h60, 13, 1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        #1;
        check_zero("midreset");
        tick();
        rst = 1'b0;
        tick();
        start_req(1'b0);
        send_bytes(8'h20, 32, 1'b0, 1'b0, 1'b0);
        check("bank_full_after_reset", bank_full, 2'b01);

        tick();
        check("wr_q_drained", wr_q.size(), 0);
        check("done_q_drained", done_q.size(), 0);

        $display("%0d/%0d checks passed", checks_pass, checks_total);
        $finish;
    end

endmodule
